div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle controller for the M-extension divide group: DIV, DIVU, REM, REMU.
- Sits beside the EX stage. EX raises start_i with its operands, and div_ctrl asserts stall_o to freeze IF/ID/EX until the result is ready.
- Runs a 32-iteration radix-2 restoring division, performs sign correction, and returns rd data with a one-cycle done pulse.
- Handles RISC-V divide-by-zero and overflow without iterating, and supports pipeline flush (kill).

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; the counter runs 0..XLEN-1.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, synchronous, active-high (asserted = 1).
- start_i  input  1  EX holds a divide instruction; level, held while stalled.
- kill_i  input  1  flush; abort the current/requested operation.
- funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- dividend_i  input  XLEN  op1 (rs1).
- divisor_i  input  XLEN  op2 (rs2).
- rd_addr_i  input  5  destination register.
- stall_o  output  1  hold the pipeline upstream of EX.
- busy_o  output  1  state != IDLE.
- done_o  output  1  one-cycle result-valid pulse.
- result_o  output  XLEN  quotient or remainder.
- rd_addr_o  output  5  latched rd.
- regs_wen_o  output  1  equals done_o.

Behaviour:
- Reset: state=IDLE, cnt=0; all datapath registers, result_o, rd_addr_o, done_o and regs_wen_o are 0.
- Reset mid-operation: the operation is discarded and no done pulse is produced.
- States: IDLE, CALC, END.
- accept = (state==IDLE) & start_i & ~kill_i & ~done_o.
  - The ~done_o term stops the still-held instruction from restarting in its completion cycle.
- On accept, latch:
  - funct3_i, rd_addr_i;
  - |dividend| and |divisor| (signed ops) or raw values (unsigned ops);
  - quotient sign = dividend[31]^divisor[31] (signed only);
  - remainder sign = dividend[31] (signed only).
- Transition out of IDLE on accept:
  - divisor==0: go to END with the special result. Quotient = all ones; remainder = dividend_i unmodified.
  - Signed op with dividend==0x80000000 and divisor==0xFFFFFFFF: go to END. Quotient = 0x80000000; remainder = 0.
  - Otherwise: go to CALC with cnt=0, partial remainder=0.
- CALC, one iteration per cycle, MSB first:
  - r' = {r, q_msb}.
  - If r' >= divisor: r = r' - divisor, shift in quotient bit 1; else r = r', shift in 0.
  - Uses a 33-bit subtract.
  - At cnt==31, go to END.
- END:
  - Apply sign correction: negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Register result_o and rd_addr_o, pulse done_o=regs_wen_o=1 for one cycle, return to IDLE.
  - Special-case results bypass sign correction.
- Latency, with start sampled at edge T:
  - Normal op: done_o high in the cycle after edge T+33.
  - Special case: done_o high in the cycle after edge T+1.
- result_o holds its value after done until the next done or reset.
- stall_o (combinational) = (state != IDLE) | (start_i & ~kill_i & ~done_o).
  - stall_o is low in the done cycle, so EX consumes result_o and advances.
- kill_i:
  - In CALC or END: next state IDLE, no done pulse, result_o unchanged.
  - In IDLE: beats start_i, so nothing is accepted.
  - Kill has priority over completion: kill in END suppresses done.
- start_i changes while busy are ignored; operands are latched only at accept.
- Back-to-back divides:
  - A new start is accepted no earlier than the cycle after done.
  - done_o is never high for two consecutive cycles.

Test Plan:
- DIV 100/7, start at T -> stall_o high T..T+33; done_o pulse after edge T+33; result_o=14, regs_wen_o=1, rd_addr_o echoed.
- REM -100 (0xFFFFFF9C) % 7 -> result_o=0xFFFFFFFE (-2). DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF%10 -> 5.
- DIVU 5/0 -> done after 2 edges, result 0xFFFFFFFF. REM 5%0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM 0x80000000%-1 -> 0.
- DIV 1000/3 with kill_i pulsed at iteration 10 -> no done, busy_o low next cycle. A new DIV 9/3 started the following cycle -> 3.
- rstn asserted at iteration 20 -> all outputs 0 next edge, state IDLE, no done.
- start_i held high through completion -> exactly one done pulse and no restart. Two divides back-to-back -> done pulses ≥34 cycles apart; each result is correct.

Source files
------------

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle controller for the RISC-V M-extension divide group
// (DIV, DIVU, REM, REMU). It sits beside EX, freezes the upstream pipeline
// while a divide is in flight, runs a radix-2 restoring division (one
// quotient bit per cycle, MSB first), applies sign correction and returns
// the rd write data with a one-cycle done pulse. Divide-by-zero and signed
// overflow are resolved at accept time without iterating.
//
// Ports
//   clk         rising-edge clock
//   rstn        synchronous reset, active-high (1 = reset)
//   start_i     EX holds a divide instruction (level, held while stalled)
//   kill_i      pipeline flush, aborts the current or requested operation
//   funct3_i    100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i  rs1 operand
//   divisor_i   rs2 operand
//   rd_addr_i   destination register of the instruction in EX
//   stall_o     hold IF/ID/EX
//   busy_o      controller is not idle
//   done_o      one-cycle result-valid pulse
//   result_o    quotient or remainder, held until the next done or reset
//   rd_addr_o   destination register latched at accept
//   regs_wen_o  register-file write enable, identical to done_o
// -----------------------------------------------------------------------------
module div_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [4:0]      rd_addr_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o,
   output logic            regs_wen_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_END  = 2'd2
   } state_t;

   localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   // Two's-complement negation used for operand magnitudes and sign fix-up.
   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
      return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        funct3;
   logic [4:0]        rd_lat;
   logic [XLEN-1:0]   quo;       // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0]   rem;       // partial remainder, always < divisor
   logic [XLEN-1:0]   dvs;       // divisor magnitude
   logic              quo_neg;
   logic              rem_neg;
   logic              special;
   logic [XLEN-1:0]   spec_res;
   logic              done;
   logic [XLEN-1:0]   result;
   logic [4:0]        rd_out;

   logic              signed_op;
   logic              div_zero;
   logic              overflow;
   logic              accept;
   logic [XLEN-1:0]   dvd_abs;
   logic [XLEN-1:0]   dvs_abs;
   logic [XLEN:0]     trial;
   logic [XLEN:0]     diff;
   logic              ge;
   logic [XLEN-1:0]   rem_nxt;
   logic [XLEN-1:0]   fin_quo;
   logic [XLEN-1:0]   fin_rem;
   logic [XLEN-1:0]   fin_res;

   // Operand decode, accept qualification and the iteration datapath.
   always_comb begin
      signed_op = ~funct3_i[0];
      div_zero  = (divisor_i == ZERO);
      overflow  = signed_op & (dividend_i == MIN_NEG) & (divisor_i == ONES);
      // ~done keeps the still-held instruction from restarting in its completion cycle
      accept    = (state == ST_IDLE) & start_i & ~kill_i & ~done;

      if (signed_op & dividend_i[XLEN-1]) begin
         dvd_abs = negate(dividend_i);
      end else begin
         dvd_abs = dividend_i;
      end
      if (signed_op & divisor_i[XLEN-1]) begin
         dvs_abs = negate(divisor_i);
      end else begin
         dvs_abs = divisor_i;
      end

      // 33-bit trial subtract: no borrow out means trial >= divisor
      trial = {rem, quo[XLEN-1]};
      diff  = trial - {1'b0, dvs};
      ge    = ~diff[XLEN];
      if (ge) begin
         rem_nxt = diff[XLEN-1:0];
      end else begin
         rem_nxt = trial[XLEN-1:0];
      end

      if (quo_neg) begin
         fin_quo = negate(quo);
      end else begin
         fin_quo = quo;
      end
      if (rem_neg) begin
         fin_rem = negate(rem);
      end else begin
         fin_rem = rem;
      end

      // special-case results were fully formed at accept and skip sign fix-up
      if (special) begin
         fin_res = spec_res;
      end else if (funct3[1]) begin
         fin_res = fin_rem;
      end else begin
         fin_res = fin_quo;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; kill returns to IDLE from any busy state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (div_zero | overflow) begin
                  state_nxt = ST_END;
               end else begin
                  state_nxt = ST_CALC;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (kill_i) begin
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_END;
            end else begin
               state_nxt = ST_CALC;
            end
         end
         ST_END: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Operand latching, iteration registers and registered result/done.
   always_ff @(posedge clk) begin
      if (rstn) begin
         cnt      <= CNT_ZERO;
         funct3   <= 3'b000;
         rd_lat   <= 5'd0;
         quo      <= ZERO;
         rem      <= ZERO;
         dvs      <= ZERO;
         quo_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         special  <= 1'b0;
         spec_res <= ZERO;
         done     <= 1'b0;
         result   <= ZERO;
         rd_out   <= 5'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  funct3   <= funct3_i;
                  rd_lat   <= rd_addr_i;
                  quo      <= dvd_abs;
                  dvs      <= dvs_abs;
                  rem      <= ZERO;
                  cnt      <= CNT_ZERO;
                  quo_neg  <= signed_op & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                  rem_neg  <= signed_op & dividend_i[XLEN-1];
                  special  <= div_zero | overflow;
                  if (div_zero) begin
                     spec_res <= funct3_i[1] ? dividend_i : ONES;
                  end else begin
                     spec_res <= funct3_i[1] ? ZERO : MIN_NEG;
                  end
               end
            end
            ST_CALC: begin
               if (!kill_i) begin
                  rem <= rem_nxt;
                  quo <= {quo[XLEN-2:0], ge};
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_END: begin
               if (!kill_i) begin
                  result <= fin_res;
                  rd_out <= rd_lat;
                  done   <= 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o     = (state != ST_IDLE);
   // stall drops in the done cycle so EX takes result_o and moves on
   assign stall_o    = busy_o | (start_i & ~kill_i & ~done);
   assign done_o     = done;
   assign regs_wen_o = done;
   assign result_o   = result;
   assign rd_addr_o  = rd_out;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl. A cycle-level reference (countdown to
// completion plus arithmetic result from RISC-V divide rules) is compared
// against every DUT output on every cycle; directed operations add literal
// expectations for results and latencies, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic        kill = 1'b0;
   logic [2:0]  funct3 = 3'b100;
   logic [31:0] dividend = 32'd0;
   logic [31:0] divisor = 32'd0;
   logic [4:0]  rd_addr = 5'd0;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        regs_wen_o;

   int checks = 0;
   int failures = 0;
   bit armed = 1'b0;

   div_ctrl #(.XLEN(32), .CNT_W(5)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (start),
      .kill_i     (kill),
      .funct3_i   (funct3),
      .dividend_i (dividend),
      .divisor_i  (divisor),
      .rd_addr_i  (rd_addr),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .rd_addr_o  (rd_addr_o),
      .regs_wen_o (regs_wen_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result of a divide-group instruction.
   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return f3[1] ? 32'd0 : 32'h8000_0000;
      if (!f3[0]) return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
      return f3[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Reference state: cycles left until the done pulse, pending result.
   int          m_left = 0;
   bit          m_done = 1'b0;
   bit          m_nd;
   logic [31:0] m_result = 32'd0;
   logic [4:0]  m_rd = 5'd0;
   logic [31:0] m_pend = 32'd0;
   logic [4:0]  m_pend_rd = 5'd0;
   bit          prev_done = 1'b0;

   // Reference model update on each clock edge from the same inputs the DUT samples.
   always @(posedge clk) begin
      if (rstn) begin
         m_left = 0;
         m_done = 1'b0;
         m_result = 32'd0;
         m_rd = 5'd0;
      end else begin
         m_nd = 1'b0;
         if (m_left != 0) begin
            if (kill) begin
               m_left = 0;
            end else begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_nd = 1'b1;
                  m_result = m_pend;
                  m_rd = m_pend_rd;
               end
            end
         end else if (start && !kill && !m_done) begin
            m_pend = ref_res(funct3, dividend, divisor);
            m_pend_rd = rd_addr;
            m_left = is_special(funct3, dividend, divisor) ? 1 : 33;
         end
         m_done = m_nd;
      end
   end

   // Per-cycle comparison of every output against the reference.
   always @(negedge clk) begin
      if (armed) begin
         chk("done", 32'(done_o), 32'(m_done));
         chk("regs_wen", 32'(regs_wen_o), 32'(m_done));
         chk("busy", 32'(busy_o), 32'(m_left != 0));
         chk("stall", 32'(stall_o), 32'((m_left != 0) || (start && !kill && !m_done)));
         chk("result", result_o, m_result);
         chk("rd_addr", 32'(rd_addr_o), 32'(m_rd));
         if (done_o && prev_done) chk("done_twice", 32'(1), 32'(0));
         prev_done = done_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Issue one divide and wait (bounded) for its done pulse; start is left high.
   task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int n;
      n = 0;
      start = 1'b1;
      funct3 = f3;
      dividend = a;
      divisor = b;
      rd_addr = rd;
      do begin
         step();
         n++;
      end while (!done_o && n < 40);
      chk({nm, " done"}, 32'(done_o), 32'(1));
      chk({nm, " result"}, result_o, exp);
      chk({nm, " rd"}, 32'(rd_addr_o), 32'(rd));
      chk({nm, " wen"}, 32'(regs_wen_o), 32'(1));
      chk({nm, " latency"}, 32'(n), 32'(exp_lat));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      // pin the reference arithmetic to hand-computed values
      chk("pin div", ref_res(3'b100, 32'd100, 32'd7), 32'd14);
      chk("pin rem neg", ref_res(3'b110, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
      chk("pin div trunc", ref_res(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      chk("pin rem negdiv", ref_res(3'b110, 32'd7, 32'hFFFF_FFFE), 32'd1);
      chk("pin remu", ref_res(3'b111, 32'hFFFF_FFFF, 32'd10), 32'd5);

      // reset state
      rstn = 1'b1;
      step(); step(); step();
      armed = 1'b1;
      chk("reset result", result_o, 32'd0);
      chk("reset done", 32'(done_o), 32'd0);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset rd", 32'(rd_addr_o), 32'd0);
      rstn = 1'b0;
      step();

      // normal op, start held through completion without restart
      run_op("div 100/7", 3'b100, 32'd100, 32'd7, 5'd5, 32'd14, 34);
      step();
      chk("held no restart busy", 32'(busy_o), 32'd0);
      chk("held no restart done", 32'(done_o), 32'd0);
      start = 1'b0;
      step();

      // back-to-back: second start presented in the done cycle
      run_op("rem -100%7", 3'b110, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE, 34);
      run_op("divu ffffffff/2", 3'b101, 32'hFFFF_FFFF, 32'd2, 5'd7, 32'h7FFF_FFFF, 35);
      start = 1'b0;
      step();
      run_op("remu ffffffff%10", 3'b111, 32'hFFFF_FFFF, 32'd10, 5'd8, 32'd5, 34);
      start = 1'b0;
      step();

      // special cases
      run_op("divu 5/0", 3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2);
      start = 1'b0;
      step();
      run_op("rem 5%0", 3'b110, 32'd5, 32'd0, 5'd10, 32'd5, 2);
      start = 1'b0;
      step();
      run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2);
      start = 1'b0;
      step();
      run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 2);
      start = 1'b0;
      step();

      // kill at iteration 10, then a fresh divide the following cycle
      start = 1'b1; funct3 = 3'b100; dividend = 32'd1000; divisor = 32'd3; rd_addr = 5'd13;
      for (int i = 0; i < 11; i++) step();
      kill = 1'b1;
      step();
      kill = 1'b0;
      chk("kill busy", 32'(busy_o), 32'd0);
      chk("kill done", 32'(done_o), 32'd0);
      run_op("div 9/3", 3'b100, 32'd9, 32'd3, 5'd14, 32'd3, 34);
      start = 1'b0;
      step();

      // reset at iteration 20
      start = 1'b1; funct3 = 3'b100; dividend = 32'd1000; divisor = 32'd3; rd_addr = 5'd15;
      for (int i = 0; i < 21; i++) step();
      rstn = 1'b1;
      step();
      chk("midreset result", result_o, 32'd0);
      chk("midreset busy", 32'(busy_o), 32'd0);
      chk("midreset done", 32'(done_o), 32'd0);
      chk("midreset rd", 32'(rd_addr_o), 32'd0);
      rstn = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 40; i++) step();

      // randomized phase: operands change every cycle, occasional kill/reset
      for (int c = 0; c < 4000; c++) begin
         rstn = ($urandom_range(0, 599) == 0);
         kill = ($urandom_range(0, 39) == 0);
         start = ($urandom_range(0, 3) != 0);
         funct3 = {1'b1, 2'($urandom_range(0, 3))};
         dividend = pick();
         divisor = pick();
         rd_addr = 5'($urandom);
         step();
      end
      rstn = 1'b0; kill = 1'b0; start = 1'b0;
      for (int i = 0; i < 40; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
